pn_period_ctrl: RTL and testbench

- Sequencing controller for the runtime-configurable PN (LFSR) generator.
- Accepts a configuration command (length N, characteristic polynomial, seed, bit budget) through a valid/ready handshake, then steps the shift register once per accepted output bit.
- Streams the output bits to a consumer.
- Measures the sequence period and reports whether the polynomial is maximal-length.

---
 rtl/pn_pkg.sv | 28 ++
 rtl/pn_lfsr_step.sv | 31 +++
 rtl/pn_period_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pn_period_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pn_pkg.sv
// Shared types and helpers for the PN sequencing controller.
// The optional PN_CTRL_AUTOSTOP_EN build ends a run once the period is found.
package pn_pkg;

    localparam int MAX_N = 13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } pn_state_e;

    // Bits 0..n-1 set.
    function automatic logic [MAX_N-1:0] n_mask(input logic [3:0] n);
        logic [MAX_N-1:0] m;
        for (int i = 0; i < MAX_N; i++) begin
            m[i] = (i < int'(n));
        end
        return m;
    endfunction

    // Period of a maximal-length register of length n.
    function automatic logic [31:0] max_period(input logic [3:0] n);
        return (32'd1 << n) - 32'd1;
    endfunction

endpackage

// File: rtl/pn_lfsr_step.sv
// Combinational next state of a length-n Fibonacci shift register:
// shift towards bit 0, feedback XOR of tapped bits into bit n-1, bits >= n cleared.
module pn_lfsr_step
    import pn_pkg::*;
(
    input  logic [MAX_N-1:0] cur_state,
    input  logic [MAX_N-1:0] poly,
    input  logic [3:0]       n,
    output logic [MAX_N-1:0] next_state
);

    logic             fb_s;
    logic [MAX_N-1:0] shifted_s;

    // Shift, inject feedback at the top active bit, clear unused bits.
    always_comb begin
        fb_s       = ^(cur_state & poly);
        shifted_s  = cur_state >> 1;
        next_state = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < int'(n) - 1) begin
                next_state[i] = shifted_s[i];
            end else if (i == int'(n) - 1) begin
                next_state[i] = fb_s;
            end else begin
                next_state[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/pn_period_ctrl.sv
// Sequencing controller for the runtime-configurable PN generator: command
// intake, bit streaming and period measurement. Build option: PN_CTRL_AUTOSTOP_EN.
module pn_period_ctrl
    import pn_pkg::*;
#(
    parameter int LEN_W = 16,
    parameter int MAX_N = pn_pkg::MAX_N
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [3:0]       cfg_n,
    input  logic [MAX_N-1:0] cfg_poly,
    input  logic [MAX_N-1:0] cfg_init,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             abort,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             bit_data,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] period,
    output logic             period_found,
    output logic             maximal,
    output logic             aborted
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_LOAD = ST_LOAD;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_DONE = ST_DONE;

    logic [1:0]       state_r, state_s;
    logic [3:0]       n_r;
    logic [MAX_N-1:0] poly_r, seed_r, lfsr_r, lfsr_next_s, cfg_mask_s;
    logic [LEN_W-1:0] len_r, cnt_r, cnt_inc_s, period_r;
    logic             period_found_r, aborted_r, err_r, done_r;
    logic             cfg_ready_r, bit_valid_r;
    logic             cmd_ok_s, accept_s, step_s, period_hit_s, last_s, autostop_s;

    pn_lfsr_step u_step (
        .cur_state  (lfsr_r),
        .poly       (poly_r),
        .n          (n_r),
        .next_state (lfsr_next_s)
    );

    // Command validation, step qualification and period detection.
    always_comb begin
        cfg_mask_s   = n_mask(cfg_n);
        cmd_ok_s     = (cfg_n >= 4'd2) && (cfg_n <= 4'(MAX_N)) && ((cfg_init & cfg_mask_s) != '0);
        accept_s     = cfg_valid && cfg_ready_r;
        step_s       = bit_valid_r && bit_ready;
        // Saturating count: a period beyond the counter range is never reported.
        if (cnt_r == '1) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + LEN_W'(1);
        end
        period_hit_s = step_s && !period_found_r && (cnt_r != '1) && (lfsr_next_s == seed_r);
        last_s       = step_s && (cnt_inc_s == len_r);
`ifdef PN_CTRL_AUTOSTOP_EN
        autostop_s   = period_hit_s;
`else
        autostop_s   = 1'b0;
`endif
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s && cmd_ok_s) begin
                    state_s = S_LOAD;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LOAD: begin
                if (len_r == '0) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_RUN;
                end
            end
            S_RUN: begin
                if (abort || last_s || autostop_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_RUN;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= S_IDLE;
            n_r            <= 4'd0;
            poly_r         <= '0;
            seed_r         <= '0;
            len_r          <= '0;
            lfsr_r         <= '0;
            cnt_r          <= '0;
            period_r       <= '0;
            period_found_r <= 1'b0;
            aborted_r      <= 1'b0;
            err_r          <= 1'b0;
            done_r         <= 1'b0;
            cfg_ready_r    <= 1'b1;
            bit_valid_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            cfg_ready_r <= (state_s == S_IDLE);
            bit_valid_r <= (state_s == S_RUN);
            done_r      <= (state_s == S_DONE);
            err_r       <= accept_s && !cmd_ok_s;
            case (state_r)
                S_IDLE: begin
                    if (accept_s && cmd_ok_s) begin
                        n_r    <= cfg_n;
                        poly_r <= cfg_poly & cfg_mask_s;
                        seed_r <= cfg_init & cfg_mask_s;
                        len_r  <= cfg_len;
                    end
                end
                S_LOAD: begin
                    lfsr_r         <= seed_r;
                    cnt_r          <= '0;
                    period_r       <= '0;
                    period_found_r <= 1'b0;
                    aborted_r      <= 1'b0;
                end
                S_RUN: begin
                    if (step_s) begin
                        lfsr_r <= lfsr_next_s;
                        cnt_r  <= cnt_inc_s;
                    end
                    if (period_hit_s) begin
                        period_r       <= cnt_inc_s;
                        period_found_r <= 1'b1;
                    end
                    if (abort) begin
                        aborted_r <= 1'b1;
                    end
                end
                default: begin
                    lfsr_r <= lfsr_r;
                end
            endcase
        end
    end

    assign cfg_ready    = cfg_ready_r;
    assign bit_valid    = bit_valid_r;
    assign bit_data     = lfsr_r[0];
    assign done         = done_r;
    assign err          = err_r;
    assign period       = period_r;
    assign period_found = period_found_r;
    assign aborted      = aborted_r;
    assign maximal      = period_found_r && (32'(period_r) == max_period(n_r));

endmodule

// File: tb/tb_pn_period_ctrl.sv
// Self-checking bench for pn_period_ctrl: directed plan cases plus randomized
// commands against a sequence-level reference model.
module tb_pn_period_ctrl;

    localparam int LEN_W = 16;
    localparam int MN    = 13;

    logic             clk = 1'b0;
    logic             reset;
    logic             cfg_valid, cfg_ready;
    logic [3:0]       cfg_n;
    logic [MN-1:0]    cfg_poly, cfg_init;
    logic [LEN_W-1:0] cfg_len;
    logic             abort, bit_valid, bit_ready, bit_data;
    logic             done, err, period_found, maximal, aborted;
    logic [LEN_W-1:0] period;

    int tests_run    = 0;
    int tests_failed = 0;

    int last_period;
    bit last_found, last_max, last_aborted;

    pn_period_ctrl #(.LEN_W(LEN_W), .MAX_N(MN)) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_n(cfg_n), .cfg_poly(cfg_poly), .cfg_init(cfg_init), .cfg_len(cfg_len),
        .abort(abort), .bit_valid(bit_valid), .bit_ready(bit_ready), .bit_data(bit_data),
        .done(done), .err(err), .period(period), .period_found(period_found),
        .maximal(maximal), .aborted(aborted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One register step straight from the rule: shift down, parity of taps into bit n-1.
    function automatic logic [MN-1:0] mstep(input logic [MN-1:0] s, input logic [MN-1:0] p, input int n);
        logic [MN-1:0] r;
        r = s >> 1;
        r[n-1] = ^(s & p);
        return r;
    endfunction

    task automatic run_cmd(input int n, input int poly, input int init, input int len,
                           input int mode, input int abort_at, input int reset_at);
        int mask, p, steps_norm, steps, pexp;
        logic [MN-1:0] s, s0, pm;
        bit ab, mx, r, seen_done;
        bit expq[$];
        bit got[$];
        mask = (1 << n) - 1;
        pm = MN'(poly & mask);
        s0 = MN'(init & mask);
        s = s0;
        p = 0;
        steps_norm = len;
        for (int k = 1; k <= len; k++) begin
            expq.push_back(s[0]);
            s = mstep(s, pm, n);
            if (s == s0 && p == 0) begin
                p = k;
`ifdef PN_CTRL_AUTOSTOP_EN
                steps_norm = k;
                break;
`endif
            end
        end
        steps = steps_norm;
        ab = 1'b0;
        if (abort_at >= 0 && abort_at < steps_norm) begin
            steps = abort_at + 1;
            ab = 1'b1;
        end
        while (expq.size() > steps) void'(expq.pop_back());
        pexp = (p != 0 && p <= steps) ? p : 0;
        mx = (pexp != 0) && (pexp == mask);

        @(negedge clk);
        check("idle_ready", cfg_ready, 1);
        cfg_valid = 1'b1;
        cfg_n = 4'(n);
        cfg_poly = MN'(poly);
        cfg_init = MN'(init);
        cfg_len = LEN_W'(len);
        @(negedge clk);
        cfg_valid = 1'b0;
        check("accept_ready_low", cfg_ready, 0);
        check("accept_no_err", err, 0);

        seen_done = 1'b0;
        for (int cyc = 0; cyc < 4 * len + 50; cyc++) begin
            @(negedge clk);
            abort = 1'b0;
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            if (reset_at >= 0 && got.size() == reset_at) begin
                bit_ready = 1'b0;
                reset = 1'b1;
                #1;
                check("rst_bit_valid", bit_valid, 0);
                check("rst_cfg_ready", cfg_ready, 1);
                check("rst_done", done, 0);
                check("rst_period", 32'(period), 0);
                check("rst_found", period_found, 0);
                check("rst_aborted", aborted, 0);
                for (int i = 0; i < got.size(); i++) check("rst_prefix_bit", got[i], expq[i]);
                @(negedge clk);
                reset = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("rst_no_done", done, 0);
                end
                last_period = 0;
                last_found = 1'b0;
                last_max = 1'b0;
                last_aborted = 1'b0;
                return;
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 2 == 0);
                default: r = ($urandom_range(0, 3) != 0);
            endcase
            bit_ready = r;
            if (bit_valid && r) begin
                got.push_back(bit_data);
                if (int'(got.size()) - 1 == abort_at) abort = 1'b1;
            end
        end

        abort = 1'b0;
        bit_ready = 1'b0;
        check("done_seen", seen_done, 1);
        check("done_bit_valid", bit_valid, 0);
        check("bit_count", got.size(), expq.size());
        for (int i = 0; i < got.size() && i < expq.size(); i++) check("bit", got[i], expq[i]);
        check("period", 32'(period), pexp);
        check("period_found", period_found, (pexp != 0));
        check("maximal", maximal, mx);
        check("aborted", aborted, ab);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("ready_after_done", cfg_ready, 1);
        last_period = pexp;
        last_found = (pexp != 0);
        last_max = mx;
        last_aborted = ab;
    endtask

    task automatic reject_cmd(input int n, input int init);
        @(negedge clk);
        check("rej_idle_ready", cfg_ready, 1);
        cfg_valid = 1'b1;
        cfg_n = 4'(n);
        cfg_poly = 13'h0003;
        cfg_init = MN'(init);
        cfg_len = 16'd10;
        @(negedge clk);
        cfg_valid = 1'b0;
        check("rej_err_pulse", err, 1);
        check("rej_ready", cfg_ready, 1);
        @(negedge clk);
        check("rej_err_clear", err, 0);
        check("rej_ready_hold", cfg_ready, 1);
        check("rej_no_run", bit_valid, 0);
        check("rej_period", 32'(period), last_period);
        check("rej_found", period_found, last_found);
        check("rej_maximal", maximal, last_max);
        check("rej_aborted", aborted, last_aborted);
    endtask

    initial begin
        int n, mask, poly, init, len, ab_at;
        reset = 1'b1;
        cfg_valid = 1'b0;
        cfg_n = 4'd0;
        cfg_poly = '0;
        cfg_init = '0;
        cfg_len = '0;
        abort = 1'b0;
        bit_ready = 1'b0;
        last_period = 0;
        last_found = 1'b0;
        last_max = 1'b0;
        last_aborted = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_cfg_ready", cfg_ready, 1);
        check("reset_bit_valid", bit_valid, 0);
        check("reset_bit_data", bit_data, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        check("reset_period", 32'(period), 0);
        check("reset_found", period_found, 0);
        check("reset_maximal", maximal, 0);
        check("reset_aborted", aborted, 0);
        reset = 1'b0;

        run_cmd(4, 'h3, 'h1, 15, 0, -1, -1);
        run_cmd(4, 'hF, 'h1, 20, 0, -1, -1);
        run_cmd(4, 'h2, 'h1, 32, 0, -1, -1);
        reject_cmd(1, 'h1);
        reject_cmd(14, 'h1);
        reject_cmd(4, 'h10);
        run_cmd(4, 'h3, 'h1, 15, 1, -1, -1);
        run_cmd(4, 'h3, 'h1, 15, 1, 6, -1);
        run_cmd(4, 'h3, 'h1, 15, 0, -1, 3);
        run_cmd(4, 'h3, 'h1, 15, 0, -1, -1);
        run_cmd(5, 'h5, 'h3, 0, 0, -1, -1);
        run_cmd(4, 'h3, 'h31, 16, 0, 15, -1);
        run_cmd(13, 'h1B01, 'h1ABC, 40, 2, -1, -1);
        run_cmd(2, 'h3, 'h2, 7, 0, -1, -1);

        for (int t = 0; t < 25; t++) begin
            n = $urandom_range(2, 7);
            mask = (1 << n) - 1;
            poly = int'($urandom) & mask;
            init = $urandom_range(1, mask);
            len = $urandom_range(0, 60);
            ab_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
            run_cmd(n, poly, init, len, 2, ab_at, -1);
            if ($urandom_range(0, 4) == 0) reject_cmd($urandom_range(0, 1) == 0 ? $urandom_range(0, 1) : $urandom_range(14, 15), init);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
